hazard_stall_ctrl: RTL and testbench

- Generates the `stall` and `stallC` control pair consumed by the 4-stage pipeline latches (F/D, D/E, E/M) and the fetch unit.
- Detects three hazard types:
  - load-use data hazards between Decode and Execute;
  - multi-cycle MUL/DIV/MOD occupancy of Execute;
  - taken-branch / call / ret control hazards that squash wrong-path instructions.
- Also keeps saturating performance counters of stall and flush cycles.
- Sits beside the decode unit; its outputs fan out to every pipeline latch.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/hazard_stall_ctrl_sat_counter.sv | 19 +
 rtl/hazard_stall_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush control: stall codes, squash codes
// and the hazard controller state type.
package pipe_ctrl_pkg;

    localparam logic [1:0] STALL_RUN     = 2'd0;
    localparam logic [1:0] STALL_BUBBLE  = 2'd1;
    localparam logic [1:0] STALL_HOLD    = 2'd2;

    localparam logic [1:0] STALLC_RUN    = 2'd0;
    localparam logic [1:0] STALLC_SQUASH = 2'd1;

    typedef enum logic [1:0] {
        IDLE,
        MULTI,
        FLUSH
    } ctrl_state_t;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance statistics.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller: load-use bubbles, multi-cycle Execute holds and taken-transfer
// squashes for the 4-stage pipeline, plus saturating stall/flush cycle counters.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT   = 3,
    parameter int DIV_LAT   = 8,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       rs1D,
    input  logic [3:0]       rs2D,
    input  logic             useRs1D,
    input  logic             useRs2D,
    input  logic [3:0]       rdE,
    input  logic             isLdE,
    input  logic             isWbE,
    input  logic             isMulE,
    input  logic             isDivE,
    input  logic             isModE,
    input  logic             branchTakenE,
    output logic [1:0]       stall,
    output logic [1:0]       stallC,
    output logic             busyE,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int MAX_CNT = (MAX_LAT > FLUSH_CYC) ? MAX_LAT : FLUSH_CYC;
    // Counters only ever hold (cycles - 2), so clog2 of the largest count suffices.
    localparam int CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0] MUL_INIT = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [CW-1:0] DIV_INIT = CW'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
    localparam logic [CW-1:0] FL_INIT  = CW'((FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0);

    ctrl_state_t   state, state_nx;
    logic [CW-1:0] mccnt, mccnt_nx;
    logic [CW-1:0] flcnt, flcnt_nx;

    logic mc_op, div_sel, lat_multi, ld_haz;

    assign mc_op     = isMulE | isDivE | isModE;
    assign div_sel   = isDivE | isModE;
    assign lat_multi = div_sel ? (DIV_LAT > 1) : (MUL_LAT > 1);
    assign ld_haz    = isLdE & isWbE &
                       ((useRs1D & (rs1D == rdE)) | (useRs2D & (rs2D == rdE)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mccnt <= '0;
            flcnt <= '0;
        end else begin
            state <= state_nx;
            mccnt <= mccnt_nx;
            flcnt <= flcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mccnt_nx = mccnt;
        flcnt_nx = flcnt;
        stall    = STALL_RUN;
        stallC   = STALLC_RUN;
        busyE    = 1'b0;
        // Outputs are gated so they fall with reset rather than at the next edge.
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (branchTakenE) begin
                        stallC = STALLC_SQUASH;
                        if (FLUSH_CYC > 1) begin
                            flcnt_nx = FL_INIT;
                            state_nx = FLUSH;
                        end
                    end else if (mc_op && lat_multi) begin
                        stall    = STALL_HOLD;
                        busyE    = 1'b1;
                        mccnt_nx = div_sel ? DIV_INIT : MUL_INIT;
                        state_nx = MULTI;
                    end else if (!mc_op && ld_haz) begin
                        stall = STALL_BUBBLE;
                    end
                end
                MULTI: begin
                    if (mccnt != '0) begin
                        stall    = STALL_HOLD;
                        busyE    = 1'b1;
                        mccnt_nx = mccnt - CW'(1);
                    end else begin
                        state_nx = IDLE;
                    end
                end
                FLUSH: begin
                    stallC = STALLC_SQUASH;
                    if (flcnt != '0) begin
                        flcnt_nx = flcnt - CW'(1);
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall != STALL_RUN),
        .count (stallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stallC != STALLC_RUN),
        .count (flushCount)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic against a
// cycle-occupancy reference model; a narrow-counter twin exercises saturation.
module tb_hazard_stall_ctrl;

    localparam int MUL_LAT   = 3;
    localparam int DIV_LAT   = 8;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 32;
    localparam int SW        = 3;
    localparam int SMAX      = (1 << SW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] rs1D, rs2D, rdE;
    logic useRs1D, useRs2D, isLdE, isWbE, isMulE, isDivE, isModE, branchTakenE;
    logic [1:0] stall, stallC, stall_s, stallC_s;
    logic busyE, busyE_s;
    logic [CNT_W-1:0] stallCount, flushCount;
    logic [SW-1:0] stallCount_s, flushCount_s;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .rdE(rdE), .isLdE(isLdE), .isWbE(isWbE), .isMulE(isMulE), .isDivE(isDivE), .isModE(isModE),
        .branchTakenE(branchTakenE), .stall(stall), .stallC(stallC), .busyE(busyE),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .FLUSH_CYC(FLUSH_CYC), .CNT_W(SW)) dut_s (
        .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .rdE(rdE), .isLdE(isLdE), .isWbE(isWbE), .isMulE(isMulE), .isDivE(isDivE), .isModE(isModE),
        .branchTakenE(branchTakenE), .stall(stall_s), .stallC(stallC_s), .busyE(busyE_s),
        .stallCount(stallCount_s), .flushCount(flushCount_s)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: an op occupies E for lat cycles (last one is the release),
    // a taken transfer squashes for FLUSH_CYC cycles.
    int mc_left, fl_left;
    longint exp_scnt, exp_fcnt;
    int exp_ss, exp_sf;
    logic [1:0] exp_stall, exp_stallC;
    logic exp_busy;

    function automatic int lat_of();
        return (isDivE | isModE) ? DIV_LAT : MUL_LAT;
    endfunction

    function automatic logic mc_req();
        return isMulE | isDivE | isModE;
    endfunction

    function automatic logic ld_haz();
        return isLdE & isWbE & ((useRs1D & (rs1D == rdE)) | (useRs2D & (rs2D == rdE)));
    endfunction

    task automatic model_reset();
        mc_left = 0; fl_left = 0;
        exp_scnt = 0; exp_fcnt = 0; exp_ss = 0; exp_sf = 0;
    endtask

    task automatic model_eval();
        exp_stall = 2'd0; exp_stallC = 2'd0; exp_busy = 1'b0;
        if (fl_left > 0) exp_stallC = 2'd1;
        else if (mc_left > 0) begin
            if (mc_left > 1) begin exp_stall = 2'd2; exp_busy = 1'b1; end
        end
        else if (branchTakenE) exp_stallC = 2'd1;
        else if (mc_req()) begin
            if (lat_of() > 1) begin exp_stall = 2'd2; exp_busy = 1'b1; end
        end
        else if (ld_haz()) exp_stall = 2'd1;
    endtask

    task automatic model_advance();
        model_eval();
        if (exp_stall != 0) begin
            if (exp_scnt < 64'hFFFF_FFFF) exp_scnt++;
            if (exp_ss < SMAX) exp_ss++;
        end
        if (exp_stallC != 0) begin
            if (exp_fcnt < 64'hFFFF_FFFF) exp_fcnt++;
            if (exp_sf < SMAX) exp_sf++;
        end
        if (fl_left > 0) fl_left--;
        else if (mc_left > 0) mc_left--;
        else if (branchTakenE) fl_left = FLUSH_CYC - 1;
        else if (mc_req()) mc_left = lat_of() - 1;
    endtask

    task automatic clear_in();
        rs1D = 0; rs2D = 0; rdE = 0; useRs1D = 0; useRs2D = 0; isLdE = 0; isWbE = 0;
        isMulE = 0; isDivE = 0; isModE = 0; branchTakenE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_in();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        branchTakenE = 1'b1; isMulE = 1'b1;
        #1;
        n_tests++;
        if (stall !== 2'd0 || stallC !== 2'd0 || busyE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: stall=%0d stallC=%0d busyE=%0d, required 0/0/0", stall, stallC, busyE);
        end
        @(negedge clk);
        n_tests++;
        if (stallCount !== '0 || flushCount !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: stallCount=%0d flushCount=%0d, required 0/0", stallCount, flushCount);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        isLdE = 1; isWbE = 1; rdE = 5; rs2D = 5; useRs2D = 1; rs1D = 3; useRs1D = 1;
        #1;
        n_tests++;
        if (stall !== 2'd1 || stallC !== 2'd0) begin
            n_fail++;
            $display("FAIL loaduse_hit: stall=%0d stallC=%0d, required 1/0", stall, stallC);
        end
        tick();
        clear_in();
        #1;
        n_tests++;
        if (stall !== 2'd0) begin
            n_fail++;
            $display("FAIL loaduse_one_cycle: stall=%0d, required 0", stall);
        end
        tick();
        n_tests++;
        if (stallCount !== 32'd1 || stallCount !== exp_scnt[CNT_W-1:0]) begin
            n_fail++;
            $display("FAIL loaduse_count: stallCount=%0d, required 1", stallCount);
        end
        isLdE = 1; isWbE = 1; rdE = 5; rs2D = 5; useRs2D = 0;
        #1;
        n_tests++;
        if (stall !== 2'd0) begin
            n_fail++;
            $display("FAIL loaduse_unused_src: stall=%0d, required 0", stall);
        end
        tick();
        rdE = 0; rs1D = 0; useRs1D = 1;
        #1;
        n_tests++;
        if (stall !== 2'd1) begin
            n_fail++;
            $display("FAIL loaduse_r0: stall=%0d, required 1", stall);
        end
        tick();
        isWbE = 0;
        #1;
        n_tests++;
        if (stall !== 2'd0) begin
            n_fail++;
            $display("FAIL loaduse_no_wb: stall=%0d, required 0", stall);
        end
        tick();
        clear_in();
    endtask

    task automatic test_multi_cycle();
        do_reset();
        isMulE = 1;
        for (int c = 0; c < MUL_LAT; c++) begin
            logic [1:0] want;
            want = (c < MUL_LAT - 1) ? 2'd2 : 2'd0;
            #1;
            n_tests++;
            if (stall !== want || busyE !== (want == 2'd2)) begin
                n_fail++;
                $display("FAIL mul_cycle%0d: stall=%0d busyE=%0d, required %0d/%0d", c, stall, busyE, want, want == 2'd2);
            end
            if (c == MUL_LAT - 1) clear_in();
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            do_reset();
            if (k == 0) isDivE = 1; else isModE = 1;
            for (int c = 0; c < DIV_LAT; c++) begin
                logic [1:0] want;
                want = (c < DIV_LAT - 1) ? 2'd2 : 2'd0;
                #1;
                n_tests++;
                if (stall !== want || busyE !== (want == 2'd2)) begin
                    n_fail++;
                    $display("FAIL %s_cycle%0d: stall=%0d busyE=%0d, required %0d", k == 0 ? "div" : "mod", c, stall, busyE, want);
                end
                if (c == DIV_LAT - 1) clear_in();
                tick();
            end
            n_tests++;
            if (stallCount !== 32'(DIV_LAT - 1)) begin
                n_fail++;
                $display("FAIL div_count%0d: stallCount=%0d, required %0d", k, stallCount, DIV_LAT - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] pat [6] = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd0};
        do_reset();
        isMulE = 1;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_tests++;
            if (stall !== pat[c]) begin
                n_fail++;
                $display("FAIL b2b_mul_cycle%0d: stall=%0d, required %0d", c, stall, pat[c]);
            end
            tick();
        end
        clear_in();
        tick();
        n_tests++;
        if (stallCount !== 32'd4) begin
            n_fail++;
            $display("FAIL b2b_count: stallCount=%0d, required 4", stallCount);
        end
    endtask

    task automatic test_branch();
        logic [1:0] pat [3] = '{2'd1, 2'd1, 2'd0};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            branchTakenE = (c < 2);
            #1;
            n_tests++;
            if (stallC !== pat[c] || stall !== 2'd0) begin
                n_fail++;
                $display("FAIL branch_cycle%0d: stallC=%0d stall=%0d, required %0d/0", c, stallC, stall, pat[c]);
            end
            tick();
        end
        n_tests++;
        if (flushCount !== 32'd2) begin
            n_fail++;
            $display("FAIL branch_count: flushCount=%0d, required 2", flushCount);
        end
    endtask

    task automatic test_priority();
        do_reset();
        branchTakenE = 1; isLdE = 1; isWbE = 1; rdE = 7; rs1D = 7; useRs1D = 1;
        #1;
        n_tests++;
        if (stallC !== 2'd1 || stall !== 2'd0) begin
            n_fail++;
            $display("FAIL prio_branch_ld: stallC=%0d stall=%0d, required 1/0", stallC, stall);
        end
        do_reset();
        branchTakenE = 1; isDivE = 1;
        #1;
        n_tests++;
        if (stallC !== 2'd1 || stall !== 2'd0 || busyE !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_branch_div: stallC=%0d stall=%0d busyE=%0d, required 1/0/0", stallC, stall, busyE);
        end
        tick();
        clear_in();
    endtask

    task automatic test_saturation();
        do_reset();
        isDivE = 1;
        for (int c = 0; c < DIV_LAT + 3; c++) begin
            if (c == DIV_LAT) begin
                #1;
                n_tests++;
                if (stallCount_s !== SW'(SMAX)) begin
                    n_fail++;
                    $display("FAIL sat_reach: stallCount=%0d, required %0d", stallCount_s, SMAX);
                end
            end
            tick();
        end
        clear_in();
        n_tests++;
        if (stallCount_s !== SW'(SMAX) || stallCount !== 32'(DIV_LAT + 2)) begin
            n_fail++;
            $display("FAIL sat_hold: narrow=%0d wide=%0d, required %0d/%0d", stallCount_s, stallCount, SMAX, DIV_LAT + 2);
        end
    endtask

    task automatic test_reset_mid_multi();
        do_reset();
        isDivE = 1;
        tick(); tick(); tick();
        #1;
        n_tests++;
        if (stall !== 2'd2) begin
            n_fail++;
            $display("FAIL midreset_pre: stall=%0d, required 2", stall);
        end
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if (stall !== 2'd0 || busyE !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: stall=%0d busyE=%0d, required 0/0", stall, busyE);
        end
        clear_in();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (stall !== 2'd0 || stallCount !== '0) begin
            n_fail++;
            $display("FAIL midreset_after: stall=%0d stallCount=%0d, required 0/0", stall, stallCount);
        end
        isMulE = 1;
        #1;
        n_tests++;
        if (stall !== 2'd2 || busyE !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_idle: stall=%0d busyE=%0d, required 2/1", stall, busyE);
        end
        tick();
        clear_in();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rdE = 4'($urandom_range(0, 15));
            rs1D = ($urandom_range(0, 2) == 0) ? rdE : 4'($urandom_range(0, 15));
            rs2D = ($urandom_range(0, 2) == 0) ? rdE : 4'($urandom_range(0, 15));
            useRs1D = 1'($urandom_range(0, 1));
            useRs2D = 1'($urandom_range(0, 1));
            isLdE = ($urandom_range(0, 2) == 0);
            isWbE = ($urandom_range(0, 3) != 0);
            isMulE = ($urandom_range(0, 9) == 0);
            isDivE = ($urandom_range(0, 14) == 0);
            isModE = ($urandom_range(0, 14) == 0);
            branchTakenE = ($urandom_range(0, 7) == 0);
            #1;
            model_eval();
            n_tests++;
            if (stall !== exp_stall || stallC !== exp_stallC || busyE !== exp_busy) begin
                n_fail++;
                $display("FAIL rand_ctrl c%0d: stall/stallC/busyE=%0d/%0d/%0d, required %0d/%0d/%0d",
                         c, stall, stallC, busyE, exp_stall, exp_stallC, exp_busy);
            end
            n_tests++;
            if (stallCount !== exp_scnt[CNT_W-1:0] || flushCount !== exp_fcnt[CNT_W-1:0] ||
                stallCount_s !== SW'(exp_ss) || flushCount_s !== SW'(exp_sf)) begin
                n_fail++;
                $display("FAIL rand_counts c%0d: %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d", c,
                         stallCount, flushCount, stallCount_s, flushCount_s, exp_scnt, exp_fcnt, exp_ss, exp_sf);
            end
            n_tests++;
            if (stall != 2'd0 && stallC != 2'd0) begin
                n_fail++;
                $display("FAIL rand_exclusive c%0d: stall=%0d stallC=%0d, required one zero", c, stall, stallC);
            end
            tick();
        end
        clear_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_in();
        model_reset();
        test_reset();
        test_load_use();
        test_multi_cycle();
        test_back_to_back();
        test_branch();
        test_priority();
        test_saturation();
        test_reset_mid_multi();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
